// File: rtl/mii_rx_pkg.sv
// +----------------------------------------------------------------------------+
// | mii_rx_pkg: shared states, MII framing nibbles and CRC-32 constants.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package mii_rx_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_IDLE = 3'd0,
        ST_IDLE      = 3'd1,
        ST_PREAMBLE  = 3'd2,
        ST_DATA_LO   = 3'd3,
        ST_DATA_HI   = 3'd4
    } rx_state_e;

    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;

    // Reflected CRC: the nibble enters LSB first, one polynomial step per bit.
    function automatic logic [31:0] crc32_nibble_step(input logic [31:0] crc,
                                                      input logic [3:0]  nib);
        logic [31:0] c;
        c = crc ^ {28'd0, nib};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ({1'b0, c[31:1]} ^ CRC32_POLY_REFL) : {1'b0, c[31:1]};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mii_rx_byte_assembler_if.sv
// +----------------------------------------------------------------------------+
// | mii_rx_byte_assembler_if: MII receive nibbles in, byte stream + status out.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface mii_rx_byte_assembler_if;

    logic [3:0] mii_rxd;
    logic       mii_rx_dv;
    logic       mii_rx_er;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tlast;
    logic       m_axis_tuser;
    logic       stat_rx_frame_good;
    logic       stat_rx_frame_bad;

    // master: the assembler itself; slave: PHY-side source plus FIFO-side sink.
    modport master (
        input  mii_rxd, mii_rx_dv, mii_rx_er,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output stat_rx_frame_good, stat_rx_frame_bad
    );

    modport slave (
        output mii_rxd, mii_rx_dv, mii_rx_er,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  stat_rx_frame_good, stat_rx_frame_bad
    );

endinterface

`default_nettype wire

// File: rtl/crc32_nibble.sv
// +----------------------------------------------------------------------------+
// | crc32_nibble: combinational reflected CRC-32 update by one 4-bit nibble.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module crc32_nibble
    import mii_rx_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [3:0]  nibble_i,
    output logic [31:0] crc_o
);

    assign crc_o = crc32_nibble_step(crc_i, nibble_i);

endmodule

`default_nettype wire

// File: rtl/mii_rx_byte_assembler.sv
// +----------------------------------------------------------------------------+
// | mii_rx_byte_assembler: strips preamble/SFD, packs MII nibbles into bytes.  |
// | Optional FCS check: define MII_RX_FCS_CHECK_EN.               Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module mii_rx_byte_assembler
    import mii_rx_pkg::*;
#(
    parameter int MAX_FRAME_LEN = 1522,
    parameter int LEN_W         = 11
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    mii_rx_byte_assembler_if.master        bus
);

    localparam logic [LEN_W-1:0] LAST_CNT = LEN_W'(MAX_FRAME_LEN - 1);

    rx_state_e        state_q, state_d;
    logic [3:0]       lo_q, lo_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    logic [7:0]       tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic             tlast_q, tlast_d;
    logic             tuser_q, tuser_d;
    logic             good_q, good_d;
    logic             bad_q, bad_d;

    logic [7:0]       w_byte;
    logic             w_crc_bad;
    logic             w_is_sfd;

    assign w_byte   = {bus.mii_rxd, lo_q};
    assign w_is_sfd = (state_q == ST_PREAMBLE) && bus.mii_rx_dv && (bus.mii_rxd == SFD_NIBBLE);

`ifdef MII_RX_FCS_CHECK_EN
    logic [31:0] crc_q, crc_d, w_crc_next;

    crc32_nibble u_crc32_nibble (
        .crc_i    (crc_q),
        .nibble_i (bus.mii_rxd),
        .crc_o    (w_crc_next)
    );

    always_comb begin
        crc_d = crc_q;
        if (w_is_sfd) begin
            crc_d = CRC32_INIT;
        end else if (((state_q == ST_DATA_LO) || (state_q == ST_DATA_HI)) && bus.mii_rx_dv) begin
            crc_d = w_crc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC32_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign w_crc_bad = (crc_q != CRC32_RESIDUE);
`else
    assign w_crc_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        lo_d       = lo_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        tdata_d    = 8'h00;
        tvalid_d   = 1'b0;
        tlast_d    = 1'b0;
        tuser_d    = 1'b0;
        good_d     = 1'b0;
        bad_d      = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                err_d      = 1'b0;
                hold_vld_d = 1'b0;
                cnt_d      = '0;
                if (!bus.mii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                err_d      = 1'b0;
                hold_vld_d = 1'b0;
                cnt_d      = '0;
                if (bus.mii_rx_dv) begin
                    state_d = (bus.mii_rxd == PREAMBLE_NIBBLE) ? ST_PREAMBLE : ST_WAIT_IDLE;
                end
            end

            ST_PREAMBLE: begin
                if (!bus.mii_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (bus.mii_rxd == SFD_NIBBLE) begin
                    state_d    = ST_DATA_LO;
                    err_d      = bus.mii_rx_er;
                    cnt_d      = '0;
                    hold_vld_d = 1'b0;
                end else if (bus.mii_rxd != PREAMBLE_NIBBLE) begin
                    state_d = ST_WAIT_IDLE;
                end
            end

            ST_DATA_LO, ST_DATA_HI: begin
                if (!bus.mii_rx_dv) begin
                    // End of frame; a fall in DATA_HI leaves a dribble nibble behind.
                    state_d    = ST_IDLE;
                    hold_vld_d = 1'b0;
                    err_d      = 1'b0;
                    if (hold_vld_q) begin
                        tdata_d  = hold_q;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                        tuser_d  = err_q | (state_q == ST_DATA_HI) | w_crc_bad;
                        good_d   = ~tuser_d;
                        bad_d    = tuser_d;
                        cnt_d    = cnt_q + LEN_W'(1);
                    end
                end else begin
                    err_d = err_q | bus.mii_rx_er;
                    if (state_q == ST_DATA_LO) begin
                        lo_d    = bus.mii_rxd;
                        state_d = ST_DATA_HI;
                    end else begin
                        state_d    = ST_DATA_LO;
                        hold_d     = w_byte;
                        hold_vld_d = 1'b1;
                        if (hold_vld_q) begin
                            tdata_d  = hold_q;
                            tvalid_d = 1'b1;
                            cnt_d    = cnt_q + LEN_W'(1);
                            // Held byte is the last one allowed: close the frame as bad.
                            if (cnt_q == LAST_CNT) begin
                                tlast_d    = 1'b1;
                                tuser_d    = 1'b1;
                                bad_d      = 1'b1;
                                state_d    = ST_WAIT_IDLE;
                                hold_vld_d = 1'b0;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WAIT_IDLE;
            lo_q       <= 4'h0;
            hold_q     <= 8'h00;
            hold_vld_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            tdata_q    <= 8'h00;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
        end
    end

    assign bus.m_axis_tdata       = tdata_q;
    assign bus.m_axis_tvalid      = tvalid_q;
    assign bus.m_axis_tlast       = tlast_q;
    assign bus.m_axis_tuser       = tuser_q;
    assign bus.stat_rx_frame_good = good_q;
    assign bus.stat_rx_frame_bad  = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_mii_rx_byte_assembler.sv
// +----------------------------------------------------------------------------+
// | tb_mii_rx_byte_assembler: directed self-checking bench for the assembler.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mii_rx_byte_assembler;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic clk;
    logic rst_n;

    mii_rx_byte_assembler_if bus();

    mii_rx_byte_assembler #(
        .MAX_FRAME_LEN (1522),
        .LEN_W         (11)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int          n_assert;
    int          n_fail;
    beat_t       beats[$];
    int          good_total;
    int          bad_total;
    logic [7:0]  tx_bytes[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat and status-pulse recorder; tasks compare against slices of it.
    always @(negedge clk) begin
        if (rst_n && bus.m_axis_tvalid)
            beats.push_back('{d: bus.m_axis_tdata, l: bus.m_axis_tlast, u: bus.m_axis_tuser});
        if (bus.stat_rx_frame_good) good_total <= good_total + 1;
        if (bus.stat_rx_frame_bad)  bad_total  <= bad_total + 1;
    end

    function automatic logic [31:0] crc_bytes(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx_bytes[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic build_frame(input int n, input logic [7:0] first, input logic with_fcs);
        logic [31:0] fcs;
        tx_bytes.delete();
        for (int i = 0; i < n; i++) tx_bytes.push_back(first + 8'(i));
        if (with_fcs) begin
            fcs = ~crc_bytes(n);
            tx_bytes.push_back(fcs[7:0]);
            tx_bytes.push_back(fcs[15:8]);
            tx_bytes.push_back(fcs[23:16]);
            tx_bytes.push_back(fcs[31:24]);
        end
    endtask

    task automatic drive_nibble(input logic [3:0] n, input logic er);
        @(negedge clk);
        bus.mii_rx_dv = 1'b1;
        bus.mii_rxd   = n;
        bus.mii_rx_er = er;
    endtask

    task automatic drive_idle(input int k);
        repeat (k) begin
            @(negedge clk);
            bus.mii_rx_dv = 1'b0;
            bus.mii_rxd   = 4'h0;
            bus.mii_rx_er = 1'b0;
        end
    endtask

    // Preamble + SFD + tx_bytes (low nibble first); er_idx selects one data nibble with rx_er.
    task automatic send_frame(input int er_idx, input logic extra_nib);
        repeat (7) drive_nibble(4'h5, 1'b0);
        drive_nibble(4'hD, 1'b0);
        for (int i = 0; i < tx_bytes.size(); i++) begin
            drive_nibble(tx_bytes[i][3:0], (2*i) == er_idx);
            drive_nibble(tx_bytes[i][7:4], (2*i+1) == er_idx);
        end
        if (extra_nib) drive_nibble(4'hA, 1'b0);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.mii_rx_dv = 1'b0;
        bus.mii_rxd   = 4'h0;
        bus.mii_rx_er = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({bus.m_axis_tdata, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser,
             bus.stat_rx_frame_good, bus.stat_rx_frame_bad} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got tdata=%h v=%b l=%b u=%b g=%b b=%b, want all 0",
                     bus.m_axis_tdata, bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tuser,
                     bus.stat_rx_frame_good, bus.stat_rx_frame_bad);
        end
        rst_n = 1'b1;
        drive_idle(3);
        n_assert++;
        if (bus.m_axis_tvalid !== 1'b0 || beats.size() != 0) begin
            n_fail++;
            $display("FAIL reset_idle: tvalid=%b beats=%0d, want 0/0", bus.m_axis_tvalid, beats.size());
        end
    endtask

    task automatic test_good_frame;
        int base, g0, b0, n;
        base = beats.size(); g0 = good_total; b0 = bad_total;
        build_frame(64, 8'h01, 1'b1);
        send_frame(-1, 1'b0);
        drive_idle(6);
        n = beats.size() - base;
        n_assert++;
        if (n != 68) begin n_fail++; $display("FAIL good_count: got %0d beats, want 68", n); end
        for (int i = 0; i < n && i < 68; i++) begin
            n_assert++;
            if (beats[base+i].d !== tx_bytes[i] || beats[base+i].l !== (i == 67)) begin
                n_fail++;
                $display("FAIL good_beat%0d: got d=%h l=%b, want d=%h l=%b",
                         i, beats[base+i].d, beats[base+i].l, tx_bytes[i], i == 67);
            end
        end
        n_assert++;
        if (n > 0 && beats[base+n-1].u !== 1'b0) begin
            n_fail++; $display("FAIL good_tuser: got %b, want 0", beats[base+n-1].u);
        end
        n_assert++;
        if (good_total - g0 != 1 || bad_total - b0 != 0) begin
            n_fail++; $display("FAIL good_stat: good=%0d bad=%0d, want 1/0", good_total - g0, bad_total - b0);
        end
    endtask

    task automatic test_rx_er;
        int base, g0, b0, n;
        base = beats.size(); g0 = good_total; b0 = bad_total;
        build_frame(64, 8'h01, 1'b1);
        send_frame(70, 1'b0);
        drive_idle(6);
        n = beats.size() - base;
        n_assert++;
        if (n != 68) begin n_fail++; $display("FAIL er_count: got %0d beats, want 68", n); end
        for (int i = 0; i < n && i < 68; i++) begin
            n_assert++;
            if (beats[base+i].d !== tx_bytes[i]) begin
                n_fail++; $display("FAIL er_beat%0d: got %h, want %h", i, beats[base+i].d, tx_bytes[i]);
            end
        end
        n_assert++;
        if (n > 0 && (beats[base+n-1].l !== 1'b1 || beats[base+n-1].u !== 1'b1)) begin
            n_fail++; $display("FAIL er_last: got l=%b u=%b, want 1/1", beats[base+n-1].l, beats[base+n-1].u);
        end
        n_assert++;
        if (good_total - g0 != 0 || bad_total - b0 != 1) begin
            n_fail++; $display("FAIL er_stat: good=%0d bad=%0d, want 0/1", good_total - g0, bad_total - b0);
        end
    endtask

    task automatic test_dribble;
        int base, b0, n;
        base = beats.size(); b0 = bad_total;
        build_frame(64, 8'h01, 1'b1);
        send_frame(-1, 1'b1);
        drive_idle(6);
        n = beats.size() - base;
        n_assert++;
        if (n != 68) begin n_fail++; $display("FAIL dribble_count: got %0d beats, want 68", n); end
        n_assert++;
        if (n > 0 && (beats[base+n-1].d !== tx_bytes[67] || beats[base+n-1].l !== 1'b1 ||
                      beats[base+n-1].u !== 1'b1)) begin
            n_fail++;
            $display("FAIL dribble_last: got d=%h l=%b u=%b, want d=%h l=1 u=1",
                     beats[base+n-1].d, beats[base+n-1].l, beats[base+n-1].u, tx_bytes[67]);
        end
        n_assert++;
        if (bad_total - b0 != 1) begin n_fail++; $display("FAIL dribble_stat: bad=%0d, want 1", bad_total - b0); end
    endtask

    task automatic test_reset_mid_frame;
        int base, g0, b0, n;
        logic found;
        drive_idle(2);
        build_frame(32, 8'h11, 1'b1);
        repeat (7) drive_nibble(4'h5, 1'b0);
        drive_nibble(4'hD, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive_nibble(tx_bytes[i][3:0], 1'b0);
            drive_nibble(tx_bytes[i][7:4], 1'b0);
        end
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid) found = 1'b1;
            else begin bus.mii_rx_dv = 1'b1; bus.mii_rxd = 4'(k + 3); end
        end
        n_assert++;
        if (!found) begin n_fail++; $display("FAIL midrst_prebeat: tvalid=0 before reset, want 1"); end
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({bus.m_axis_tdata, bus.m_axis_tvalid, bus.m_axis_tlast,
             bus.stat_rx_frame_good, bus.stat_rx_frame_bad} !== 12'd0) begin
            n_fail++;
            $display("FAIL midrst_drop: got tdata=%h v=%b l=%b, want outputs 0",
                     bus.m_axis_tdata, bus.m_axis_tvalid, bus.m_axis_tlast);
        end
        repeat (3) drive_nibble(4'h6, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        base = beats.size(); g0 = good_total; b0 = bad_total;
        // Frame still in flight after release, including preamble-like nibbles.
        for (int i = 0; i < 6; i++) drive_nibble(4'h5, 1'b0);
        drive_nibble(4'hD, 1'b0);
        for (int i = 0; i < 16; i++) drive_nibble(4'(i), 1'b0);
        drive_idle(6);
        n_assert++;
        if (beats.size() - base != 0 || good_total != g0 || bad_total != b0) begin
            n_fail++;
            $display("FAIL midrst_quiet: got %0d beats, %0d stats, want 0/0",
                     beats.size() - base, (good_total - g0) + (bad_total - b0));
        end
        base = beats.size(); g0 = good_total;
        build_frame(8, 8'hA0, 1'b1);
        send_frame(-1, 1'b0);
        drive_idle(6);
        n = beats.size() - base;
        n_assert++;
        if (n != 12 || good_total - g0 != 1) begin
            n_fail++; $display("FAIL midrst_next: got %0d beats good=%0d, want 12/1", n, good_total - g0);
        end
        for (int i = 0; i < n && i < 12; i++) begin
            n_assert++;
            if (beats[base+i].d !== tx_bytes[i]) begin
                n_fail++; $display("FAIL midrst_beat%0d: got %h, want %h", i, beats[base+i].d, tx_bytes[i]);
            end
        end
    endtask

    task automatic test_truncate;
        int base, b0, n, errs;
        base = beats.size(); b0 = bad_total;
        build_frame(1600, 8'h00, 1'b0);
        send_frame(-1, 1'b0);
        drive_idle(6);
        n = beats.size() - base;
        n_assert++;
        if (n != 1522) begin n_fail++; $display("FAIL trunc_count: got %0d beats, want 1522", n); end
        errs = 0;
        for (int i = 0; i < n && i < 1522; i++)
            if (beats[base+i].d !== tx_bytes[i] || beats[base+i].l !== (i == 1521)) errs++;
        n_assert++;
        if (errs != 0) begin n_fail++; $display("FAIL trunc_data: got %0d bad beats, want 0", errs); end
        n_assert++;
        if (n > 0 && (beats[base+n-1].l !== 1'b1 || beats[base+n-1].u !== 1'b1)) begin
            n_fail++; $display("FAIL trunc_last: got l=%b u=%b, want 1/1", beats[base+n-1].l, beats[base+n-1].u);
        end
        n_assert++;
        if (bad_total - b0 != 1) begin n_fail++; $display("FAIL trunc_stat: bad=%0d, want 1", bad_total - b0); end
    endtask

    task automatic test_back_to_back;
        int base, n;
        logic [7:0] frame_a[$];
        logic       exp_user_a;
`ifdef MII_RX_FCS_CHECK_EN
        exp_user_a = 1'b1;
`else
        exp_user_a = 1'b0;
`endif
        base = beats.size();
        build_frame(16, 8'h30, 1'b1);
        tx_bytes[17] = tx_bytes[17] ^ 8'h04;
        frame_a = tx_bytes;
        send_frame(-1, 1'b0);
        drive_idle(1);
        build_frame(16, 8'hC0, 1'b1);
        send_frame(-1, 1'b0);
        drive_idle(6);
        n = beats.size() - base;
        n_assert++;
        if (n != 40) begin n_fail++; $display("FAIL b2b_count: got %0d beats, want 40", n); end
        for (int i = 0; i < n && i < 40; i++) begin
            n_assert++;
            if (beats[base+i].d !== ((i < 20) ? frame_a[i] : tx_bytes[i-20]) ||
                beats[base+i].l !== (i == 19 || i == 39)) begin
                n_fail++;
                $display("FAIL b2b_beat%0d: got d=%h l=%b, want d=%h l=%b", i, beats[base+i].d,
                         beats[base+i].l, (i < 20) ? frame_a[i] : tx_bytes[i-20], i == 19 || i == 39);
            end
        end
        n_assert++;
        if (n == 40 && beats[base+19].u !== exp_user_a) begin
            n_fail++; $display("FAIL b2b_user_a: got %b, want %b", beats[base+19].u, exp_user_a);
        end
        n_assert++;
        if (n == 40 && beats[base+39].u !== 1'b0) begin
            n_fail++; $display("FAIL b2b_user_b: got %b, want 0", beats[base+39].u);
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        test_reset();
        test_good_frame();
        test_rx_er();
        test_dribble();
        test_reset_mid_frame();
        test_truncate();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        good_total = 0;
        bad_total  = 0;
    end

endmodule

`default_nettype wire
